// File: rtl/regfile_wb_port.sv
// Register-file write-back port: merges single-cycle ALU results with buffered
// long-latency results; the ALU always wins the port, long results wait in order.
module regfile_wb_port #(
  parameter int unsigned REG_ADDR = 5,
  parameter int unsigned REG_SIZE = 32,
  parameter int unsigned REG_N    = 32,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             alu_valid,
  input  logic [REG_ADDR-1:0]              alu_reg,
  input  logic [REG_SIZE-1:0]              alu_data,
  input  logic                             lng_valid,
  output logic                             lng_ready,
  input  logic [REG_ADDR-1:0]              lng_reg,
  input  logic [REG_SIZE-1:0]              lng_data,
  output logic                             regwrite,
  output logic [REG_ADDR-1:0]              wreg,
  output logic [REG_SIZE-1:0]              wdata,
  output logic [REG_N-1:0]                 pend_busy,
  output logic [$clog2(DEPTH+1)-1:0]       pend_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [REG_ADDR-1:0] r_reg  [DEPTH];
  logic [REG_SIZE-1:0] r_data [DEPTH];
  logic                r_live [DEPTH];
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [CNT_W-1:0]    r_count;

  logic                r_regwrite;
  logic [REG_ADDR-1:0] r_wreg;
  logic [REG_SIZE-1:0] r_wdata;

  logic w_alu_claim;
  logic w_empty;
  logic w_pop;
  logic w_push_hs;
  logic w_push;

  assign w_alu_claim = alu_valid && (alu_reg != '0);
  assign w_empty     = (r_count == '0);
  assign w_pop       = !w_alu_claim && !w_empty;
  assign lng_ready   = (r_count != CNT_W'(DEPTH));
  // A register-0 result completes the handshake but is never stored.
  assign w_push_hs   = lng_valid && lng_ready && !flush;
  assign w_push      = w_push_hs && (lng_reg != '0);

  assign regwrite   = r_regwrite;
  assign wreg       = r_wreg;
  assign wdata      = r_wdata;
  assign pend_count = r_count;

  // Pending mask covers only occupied, still-live entries.
  always_comb begin
    logic [PTR_W-1:0] w_idx;
    pend_busy = '0;
    w_idx     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && r_live[w_idx]) begin
        pend_busy[r_reg[w_idx]] = 1'b1;
      end
    end
    pend_busy[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_regwrite <= 1'b0;
      r_wreg     <= '0;
      r_wdata    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_reg[i]  <= '0;
        r_data[i] <= '0;
        r_live[i] <= 1'b0;
      end
    end else begin
      // Port selection; a dead head consumes the cycle without writing.
      if (w_alu_claim) begin
        r_regwrite <= 1'b1;
        r_wreg     <= alu_reg;
        r_wdata    <= alu_data;
      end else if (w_pop) begin
        r_regwrite <= r_live[r_rd_ptr];
        if (r_live[r_rd_ptr]) begin
          r_wreg  <= r_reg[r_rd_ptr];
          r_wdata <= r_data[r_rd_ptr];
        end
      end else begin
        r_regwrite <= 1'b0;
      end

      // WAW squash of older entries; a same-cycle push is younger and stays live.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_alu_claim && (r_reg[i] == alu_reg)) begin
          r_live[i] <= 1'b0;
        end
      end
      if (w_push) begin
        r_reg[r_wr_ptr]  <= lng_reg;
        r_data[r_wr_ptr] <= lng_data;
        r_live[r_wr_ptr] <= 1'b1;
      end

      if (flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

endmodule
